// File: rtl/sram_memtest.sv
// Async-SRAM self-test engine: writes a pattern over the full address range, reads it back,
// compares word by word and repeats for a programmable number of iterations.
module sram_memtest #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned WR_CYC = 1,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned ITER_W = 12
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              stop_on_fail,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [15:0]       err_count,
  output logic [ITER_W-1:0] iter_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dout,
  input  logic [DATA_W-1:0] sram_din,
  output logic              sram_drive,
  output logic              sram_ce_n,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam logic [15:0] WrPulseLast = 16'(WR_CYC - 1);
  localparam logic [15:0] RdWaitLast  = (RD_LAT > 1) ? 16'(RD_LAT - 2) : 16'd0;

  typedef enum logic [3:0] {
    StIdle, StWrSet, StWrPulse, StWrHold, StRdSet, StRdWait, StRdCmp, StDone, StFail
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic                sof_q, sof_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;
  logic [DATA_W-1:0]   fexp_q, fexp_d;
  logic [DATA_W-1:0]   fact_q, fact_d;
  logic [DATA_W-1:0]   exp_data;
  logic                mismatch;

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [ITER_W-1:0] i);
    logic [31:0] s;
    logic [31:0] x;
    s = 32'(a) + 32'(i);
    case (m)
      2'd0: begin
        x = s;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
      end
      2'd1:    x = s;
      2'd2:    x = 32'd1 << (s % DATA_W);
      default: x = (a[0] ^ i[0]) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
    return x[DATA_W-1:0];
  endfunction

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    iter_d   = iter_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    sof_d    = sof_q;
    done_d   = done_q;
    fail_d   = fail_q;
    err_d    = err_q;
    faddr_d  = faddr_q;
    fexp_d   = fexp_q;
    fact_d   = fact_q;
    exp_data = pattern(mode_q, addr_q, iter_q);
    mismatch = (sram_din != exp_data);

    case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          sof_d   = stop_on_fail;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          err_d   = '0;
          iter_d  = '0;
          faddr_d = '0;
          fexp_d  = '0;
          fact_d  = '0;
          addr_d  = '0;
          state_d = StWrSet;
        end
      end
      StWrSet: begin
        cnt_d   = '0;
        state_d = StWrPulse;
      end
      StWrPulse: begin
        if (cnt_q == WrPulseLast) state_d = StWrHold;
        else                      cnt_d   = cnt_q + 16'd1;
      end
      StWrHold: begin
        // All-ones address wraps to 0, which is where the read pass starts.
        addr_d  = addr_q + 1'b1;
        state_d = (&addr_q) ? StRdSet : StWrSet;
      end
      StRdSet: begin
        cnt_d   = '0;
        state_d = (RD_LAT > 1) ? StRdWait : StRdCmp;
      end
      StRdWait: begin
        if (cnt_q == RdWaitLast) state_d = StRdCmp;
        else                     cnt_d   = cnt_q + 16'd1;
      end
      StRdCmp: begin
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (!fail_q) begin
            fail_d  = 1'b1;
            faddr_d = addr_q;
            fexp_d  = exp_data;
            fact_d  = sram_din;
          end
        end
        if (mismatch && sof_q) begin
          state_d = StFail;
        end else begin
          addr_d = addr_q + 1'b1;
          if (&addr_q) begin
            iter_d = iter_q + 1'b1;
            if ((max_iter != '0) && (iter_d == max_iter)) begin
              state_d = StDone;
              done_d  = !fail_d;
            end else begin
              state_d = StWrSet;
            end
          end else begin
            state_d = StRdSet;
          end
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      iter_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      sof_q   <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      iter_q  <= iter_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      sof_q   <= sof_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
    end
  end

  // Strobes decode straight from the state register so an async reset releases them at once.
  always_comb begin
    busy       = !(state_q inside {StIdle, StDone, StFail});
    sram_drive = state_q inside {StWrSet, StWrPulse, StWrHold};
    sram_we_n  = (state_q != StWrPulse);
    sram_oe_n  = !(state_q inside {StRdSet, StRdWait, StRdCmp});
    sram_ce_n  = !(sram_drive || !sram_oe_n);
  end

  assign done       = done_q;
  assign fail       = fail_q;
  assign err_count  = err_q;
  assign iter_count = iter_q;
  assign fail_addr  = faddr_q;
  assign fail_exp   = fexp_q;
  assign fail_act   = fact_q;
  assign sram_addr  = addr_q;
  assign sram_dout  = exp_data;

endmodule

// File: tb/tb_sram_memtest.sv
// Bench for sram_memtest: two instances (16-bit/1-cycle and 8-bit/slow timing) against ideal
// SRAM models, end-of-run records checked from a scoreboard queue per instance.
module tb_sram_memtest;

  localparam int unsigned AW  = 4;
  localparam int unsigned IW  = 12;
  localparam int unsigned WC0 = 1;
  localparam int unsigned WC1 = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [IW-1:0] max_iter = '0;
  logic          stop_on_fail = 1'b0;
  logic          fault_en = 1'b0;

  logic [1:0] busy_v, done_v, fail_v, drive_v, we_n_v, oe_n_v, ce_n_v;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          done;
    logic          fail;
    logic [15:0]   err;
    logic [IW-1:0] iter;
    logic [AW-1:0] faddr;
    logic [15:0]   fexp;
    logic [15:0]   fact;
    int            drv;
    int            wel;
    int            ma;
    logic [15:0]   md;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic dn, input logic fl, input int err, input int iter,
                              input int fa, input int fe, input int fc, input int drv,
                              input int wel, input int ma, input int md);
    exp_t e;
    e.done = dn;  e.fail = fl;  e.err = 16'(err);  e.iter = IW'(iter);
    e.faddr = AW'(fa);  e.fexp = 16'(fe);  e.fact = 16'(fc);
    e.drv = drv;  e.wel = wel;  e.ma = ma;  e.md = 16'(md);
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned DW = (g == 0) ? 16 : 8;
    localparam int unsigned WC = (g == 0) ? WC0 : WC1;
    localparam int unsigned RL = (g == 0) ? 1 : 2;

    logic [DW-1:0] dout, din, fexp, fact;
    logic [AW-1:0] addr, faddr;
    logic [15:0]   err;
    logic [IW-1:0] iter;
    logic [DW-1:0] mem [16];

    sram_memtest #(
      .ADDR_W(AW), .DATA_W(DW), .WR_CYC(WC), .RD_LAT(RL), .ITER_W(IW)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .start        (start),
      .mode         (mode),
      .max_iter     (max_iter),
      .stop_on_fail (stop_on_fail),
      .busy         (busy_v[g]),
      .done         (done_v[g]),
      .fail         (fail_v[g]),
      .err_count    (err),
      .iter_count   (iter),
      .fail_addr    (faddr),
      .fail_exp     (fexp),
      .fail_act     (fact),
      .sram_addr    (addr),
      .sram_dout    (dout),
      .sram_din     (din),
      .sram_drive   (drive_v[g]),
      .sram_ce_n    (ce_n_v[g]),
      .sram_we_n    (we_n_v[g]),
      .sram_oe_n    (oe_n_v[g])
    );

    always @(posedge clk) begin
      if (!ce_n_v[g] && !we_n_v[g] && drive_v[g]) mem[addr] <= dout;
    end

    // Read fault: bit 3 stuck at 1 at address 5.
    always_comb begin
      din = '0;
      if (!ce_n_v[g] && !oe_n_v[g]) begin
        din = mem[addr];
        if (fault_en && addr == 4'd5) din[3] = 1'b1;
      end
    end

    initial begin : monitor
      exp_t          e;
      logic          busy_p = 1'b0;
      logic [AW-1:0] addr_p = '0;
      int            drv_n = 0, wel_n = 0, len = 0, viol = 0;
      forever begin
        @(negedge clk);
        if (busy_v[g] && !busy_p) begin
          drv_n = 0;
          wel_n = 0;
        end
        if (drive_v[g]) drv_n++;
        if (!we_n_v[g]) wel_n++;
        if (drive_v[g] && !oe_n_v[g]) viol++;
        if (!we_n_v[g] && len != 0 && addr != addr_p) viol++;
        if (!resetn) len = 0;
        else if (!we_n_v[g]) len++;
        else if (len != 0) begin
          if (len != int'(WC)) viol++;
          len = 0;
        end
        addr_p = addr;
        if (!busy_v[g] && busy_p) begin
          if ((g == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL dut%0d unexpected end of run: got busy fall, required none", g);
          end else begin
            e = (g == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("dut%0d done", g), 32'(done_v[g]), 32'(e.done));
            chk($sformatf("dut%0d fail", g), 32'(fail_v[g]), 32'(e.fail));
            chk($sformatf("dut%0d err_count", g), 32'(err), 32'(e.err));
            chk($sformatf("dut%0d iter_count", g), 32'(iter), 32'(e.iter));
            chk($sformatf("dut%0d fail_addr", g), 32'(faddr), 32'(e.faddr));
            chk($sformatf("dut%0d fail_exp", g), 32'(fexp), 32'(e.fexp));
            chk($sformatf("dut%0d fail_act", g), 32'(fact), 32'(e.fact));
            chk($sformatf("dut%0d idle strobes", g),
                32'({ce_n_v[g], we_n_v[g], oe_n_v[g], drive_v[g]}), 32'b1110);
            chk($sformatf("dut%0d protocol violations", g), 32'(viol), 32'd0);
            if (e.drv >= 0) begin
              chk($sformatf("dut%0d drive cycles", g), 32'(drv_n), 32'(e.drv));
              chk($sformatf("dut%0d we_n low cycles", g), 32'(wel_n), 32'(e.wel));
            end
            if (e.ma >= 0)
              chk($sformatf("dut%0d mem[%0d]", g, e.ma), 32'(mem[e.ma]), 32'(e.md));
          end
        end
        busy_p = busy_v[g];
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int c = 0; c < 20000 && (q0.size() != 0 || q1.size() != 0); c++) @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL run timeout: got %0d/%0d pending, required 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [1:0] m, input int mi, input logic sof, input logic flt,
                     input exp_t e0, input exp_t e1, input logic poke);
    mode = m;
    max_iter = IW'(mi);
    stop_on_fail = sof;
    fault_en = flt;
    q0.push_back(e0);
    q1.push_back(e1);
    pulse_start();
    if (poke) begin
      repeat (20) @(negedge clk);
      mode = 2'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_empty();
  endtask

  initial begin
    exp_t rst_e;
    rst_e = mk(0, 0, 0, 0, 0, 0, 0, -1, -1, -1, 0);
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy_v), 32'd0);
    chk("reset done/fail", 32'({done_v, fail_v}), 32'd0);
    chk("reset strobes", 32'({ce_n_v, we_n_v, oe_n_v, drive_v}), 32'b11_11_11_00);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // xorshift, 2 iterations; a stray start mid-run must not restart it.
    run(2'd0, 2, 1'b0, 1'b0,
        mk(1, 0, 0, 2, 0, 0, 0, 32 * (WC0 + 2), 32 * WC0, 1, 16'h4042),
        mk(1, 0, 0, 2, 0, 0, 0, 32 * (WC1 + 2), 32 * WC1, 1, 16'h0042), 1'b1);
    run(2'd0, 1, 1'b0, 1'b0,
        mk(1, 0, 0, 1, 0, 0, 0, 16 * (WC0 + 2), 16 * WC0, 3, 16'h6063),
        mk(1, 0, 0, 1, 0, 0, 0, 16 * (WC1 + 2), 16 * WC1, 3, 16'h0063), 1'b0);
    // Address pattern with stuck bit, stop on first failure.
    run(2'd1, 1, 1'b1, 1'b1,
        mk(0, 1, 1, 0, 5, 5, 13, 16 * (WC0 + 2), 16 * WC0, 5, 5),
        mk(0, 1, 1, 0, 5, 5, 13, 16 * (WC1 + 2), 16 * WC1, 5, 5), 1'b0);
    // Same fault, keep going for 3 iterations: one error per iteration.
    run(2'd1, 3, 1'b0, 1'b1,
        mk(0, 1, 3, 3, 5, 5, 13, 48 * (WC0 + 2), 48 * WC0, 4, 6),
        mk(0, 1, 3, 3, 5, 5, 13, 48 * (WC1 + 2), 48 * WC1, 4, 6), 1'b0);
    run(2'd3, 1, 1'b0, 1'b0,
        mk(1, 0, 0, 1, 0, 0, 0, 16 * (WC0 + 2), 16 * WC0, 3, 16'hAAAA),
        mk(1, 0, 0, 1, 0, 0, 0, 16 * (WC1 + 2), 16 * WC1, 3, 16'h00AA), 1'b0);
    run(2'd2, 1, 1'b0, 1'b0,
        mk(1, 0, 0, 1, 0, 0, 0, 16 * (WC0 + 2), 16 * WC0, 9, 16'h0200),
        mk(1, 0, 0, 1, 0, 0, 0, 16 * (WC1 + 2), 16 * WC1, 9, 16'h0002), 1'b0);

    // Asynchronous reset in the middle of a write pulse of a free-running test.
    mode = 2'd1;
    max_iter = '0;
    fault_en = 1'b0;
    q0.push_back(rst_e);
    q1.push_back(rst_e);
    pulse_start();
    for (int c = 0; c < 50 && we_n_v[0]; c++) @(negedge clk);
    chk("we_n low before reset", 32'(we_n_v[0]), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("async reset strobes", 32'({ce_n_v, we_n_v, oe_n_v, drive_v}), 32'b11_11_11_00);
    chk("async reset busy", 32'(busy_v), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_empty();

    run(2'd1, 1, 1'b0, 1'b0,
        mk(1, 0, 0, 1, 0, 0, 0, 16 * (WC0 + 2), 16 * WC0, 7, 7),
        mk(1, 0, 0, 1, 0, 0, 0, 16 * (WC1 + 2), 16 * WC1, 7, 7), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
